// File: rtl/baby_ram_arbiter_if.sv
// Bus bundle between the arbiter, the Wishbone host, the Baby core RAM port and ram_5x32.
interface baby_ram_arbiter_if;
    logic        wbs_stb_i;
    logic        wbs_cyc_i;
    logic        wbs_we_i;
    logic [3:0]  wbs_sel_i;
    logic [31:0] wbs_adr_i;
    logic [31:0] wbs_dat_i;
    logic        wbs_ack_o;
    logic [31:0] wbs_dat_o;

    logic        baby_req_i;
    logic        baby_we_i;
    logic [4:0]  baby_addr_i;
    logic [31:0] baby_data_i;
    logic        baby_ack_o;
    logic [31:0] baby_data_o;
    logic        baby_reset_o;
    logic        baby_stop_i;

    logic [4:0]  ram_addr_o;
    logic        ram_we_o;
    logic [31:0] ram_data_o;
    logic [31:0] ram_data_i;

    modport slave (
        input  wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        output wbs_ack_o, wbs_dat_o,
        input  baby_req_i, baby_we_i, baby_addr_i, baby_data_i, baby_stop_i,
        output baby_ack_o, baby_data_o, baby_reset_o,
        output ram_addr_o, ram_we_o, ram_data_o,
        input  ram_data_i
    );

    modport master (
        output wbs_stb_i, wbs_cyc_i, wbs_we_i, wbs_sel_i, wbs_adr_i, wbs_dat_i,
        input  wbs_ack_o, wbs_dat_o,
        output baby_req_i, baby_we_i, baby_addr_i, baby_data_i, baby_stop_i,
        input  baby_ack_o, baby_data_o, baby_reset_o,
        input  ram_addr_o, ram_we_o, ram_data_o,
        output ram_data_i
    );
endinterface

// File: rtl/baby_ram_arbiter.sv
// Round-robin arbiter sharing ram_5x32 between the Wishbone host and the Baby, plus the run/stop CTRL register.
// state  | meaning
// IDLE   | waiting for a request; grants and latches the winning one
// ACCESS | RAM address/write strobe driven; CTRL write commits
// RESP   | owner acked with read data; round-robin pointer updated
module baby_ram_arbiter (
    input logic               wb_clk_i,
    input logic               wb_rst_i,
    baby_ram_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
    typedef enum logic [1:0] {REG_RAM, REG_CTRL, REG_NONE} region_t;

    state_t      state, state_nxt;
    region_t     host_region, lat_region;
    logic        host_req, grant, grant_baby;
    logic        last_baby, owner_baby;
    logic        run, run_d;
    logic [4:0]  lat_addr;
    logic        lat_we, lat_sel_full;
    logic [31:0] lat_data, rd_data;
    logic        resp_ok;
    logic        unused_adr;

    assign unused_adr = ^{bus.wbs_adr_i[31:8], bus.wbs_adr_i[1:0]};
    assign host_req   = bus.wbs_cyc_i & bus.wbs_stb_i;

    always_comb begin
        host_region = REG_NONE;
        if (!bus.wbs_adr_i[7])
            host_region = REG_RAM;
        else if (bus.wbs_adr_i[7:2] == 6'h20)
            host_region = REG_CTRL;
    end

    always_comb begin
        state_nxt  = state;
        grant      = 1'b0;
        grant_baby = 1'b0;
        case (state)
            IDLE: begin
                if (host_req && bus.baby_req_i) begin
                    grant      = 1'b1;
                    grant_baby = ~last_baby;
                end else if (host_req) begin
                    grant = 1'b1;
                end else if (bus.baby_req_i) begin
                    grant      = 1'b1;
                    grant_baby = 1'b1;
                end
                if (grant)
                    state_nxt = ACCESS;
            end
            ACCESS:  state_nxt = RESP;
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state        <= IDLE;
            last_baby    <= 1'b1;
            owner_baby   <= 1'b0;
            run          <= 1'b0;
            run_d        <= 1'b0;
            lat_addr     <= '0;
            lat_we       <= 1'b0;
            lat_sel_full <= 1'b0;
            lat_data     <= '0;
            lat_region   <= REG_NONE;
        end else begin
            state <= state_nxt;
            run_d <= run;
            if (grant) begin
                owner_baby <= grant_baby;
                if (grant_baby) begin
                    lat_addr     <= bus.baby_addr_i;
                    lat_we       <= bus.baby_we_i;
                    lat_data     <= bus.baby_data_i;
                    lat_sel_full <= 1'b1;
                    lat_region   <= REG_RAM;
                end else begin
                    lat_addr     <= bus.wbs_adr_i[6:2];
                    lat_we       <= bus.wbs_we_i;
                    lat_data     <= bus.wbs_dat_i;
                    lat_sel_full <= (bus.wbs_sel_i == 4'hF);
                    lat_region   <= host_region;
                end
            end
            if (state == ACCESS && lat_we && lat_region == REG_CTRL && !owner_baby)
                run <= lat_data[0];
            if (state == RESP)
                last_baby <= owner_baby;
        end
    end

    // The write strobe is not gated by reset so a write already in ACCESS still lands.
    assign bus.ram_addr_o = lat_addr;
    assign bus.ram_data_o = lat_data;
    assign bus.ram_we_o   = (state == ACCESS) && lat_we && lat_sel_full && (lat_region == REG_RAM);

    always_comb begin
        rd_data = '0;
        case (lat_region)
            REG_RAM:  rd_data = bus.ram_data_i;
            REG_CTRL: rd_data = {30'd0, bus.baby_stop_i, run};
            default:  rd_data = '0;
        endcase
    end

    assign resp_ok         = (state == RESP) && !wb_rst_i;
    assign bus.wbs_ack_o   = resp_ok && !owner_baby;
    assign bus.baby_ack_o  = resp_ok && owner_baby;
    assign bus.wbs_dat_o   = bus.wbs_ack_o  ? rd_data : 32'd0;
    assign bus.baby_data_o = bus.baby_ack_o ? rd_data : 32'd0;

    // run_d delays release so the Baby leaves reset one edge after the CTRL write commits.
    assign bus.baby_reset_o = wb_rst_i | ~run_d;
endmodule

// File: tb/tb_baby_ram_arbiter.sv
// Randomised and directed checks of baby_ram_arbiter against a word-level memory/register model.
module tb_baby_ram_arbiter;
    logic wb_clk_i = 1'b0;
    logic wb_rst_i = 1'b1;
    logic ram_clear = 1'b1;
    int   tests = 0;
    int   fails = 0;
    int   we_cnt = 0;
    logic [4:0]  we_addr;
    logic [31:0] we_data;
    logic        br_at_ack;

    logic [31:0] env_mem [32];
    logic [31:0] ref_mem [32];
    logic        ref_run;
    logic        ref_last_baby;

    baby_ram_arbiter_if bus();

    baby_ram_arbiter dut (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .bus      (bus)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // Environment model of ram_5x32: synchronous read, old data on same-cycle write.
    always @(posedge wb_clk_i) begin
        if (ram_clear) begin
            for (int i = 0; i < 32; i++) env_mem[i] <= '0;
        end else if (bus.ram_we_o) begin
            env_mem[bus.ram_addr_o] <= bus.ram_data_o;
        end
        bus.ram_data_i <= env_mem[bus.ram_addr_o];
    end

    always @(negedge wb_clk_i) begin
        if (bus.ram_we_o) begin
            we_cnt  <= we_cnt + 1;
            we_addr <= bus.ram_addr_o;
            we_data <= bus.ram_data_o;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_host_rd(input logic [31:0] adr);
        if (!adr[7]) return ref_mem[adr[6:2]];
        if (adr[7:2] == 6'h20) return {30'd0, bus.baby_stop_i, ref_run};
        return 32'd0;
    endfunction

    task automatic model_host_wr(input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        if (!adr[7]) begin
            if (sel == 4'hF) ref_mem[adr[6:2]] = dat;
        end else if (adr[7:2] == 6'h20) begin
            ref_run = dat[0];
        end
    endtask

    task automatic model_reset();
        ref_run       = 1'b0;
        ref_last_baby = 1'b1;
    endtask

    // Called at a negedge with the DUT idle; returns one idle cycle after the last ack.
    task automatic txn(input bit h_en, input bit h_we, input logic [31:0] h_adr, input logic [31:0] h_dat,
                       input logic [3:0] h_sel, input bit b_en, input bit b_we, input logic [4:0] b_adr,
                       input logic [31:0] b_dat, output int h_cyc, output logic [31:0] h_rd,
                       output int b_cyc, output logic [31:0] b_rd);
        bit h_pend, b_pend;
        h_cyc = -1; b_cyc = -1; h_rd = 'x; b_rd = 'x;
        h_pend = h_en; b_pend = b_en;
        bus.wbs_cyc_i = h_en; bus.wbs_stb_i = h_en; bus.wbs_we_i = h_we;
        bus.wbs_adr_i = h_adr; bus.wbs_dat_i = h_dat; bus.wbs_sel_i = h_sel;
        bus.baby_req_i = b_en; bus.baby_we_i = b_we; bus.baby_addr_i = b_adr; bus.baby_data_i = b_dat;
        for (int c = 1; c <= 12 && (h_pend || b_pend); c++) begin
            @(posedge wb_clk_i);
            @(negedge wb_clk_i);
            if (h_pend && bus.wbs_ack_o) begin
                h_cyc = c; h_rd = bus.wbs_dat_o; br_at_ack = bus.baby_reset_o; h_pend = 0;
                bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
            end
            if (b_pend && bus.baby_ack_o) begin
                b_cyc = c; b_rd = bus.baby_data_o; b_pend = 0;
                bus.baby_req_i = 0;
            end
        end
        bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.baby_req_i = 0;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
    endtask

    task automatic do_op(input string tag, input bit h_en, input bit h_we, input logic [31:0] h_adr,
                         input logic [31:0] h_dat, input logic [3:0] h_sel, input bit b_en, input bit b_we,
                         input logic [4:0] b_adr, input logic [31:0] b_dat);
        bit host_first;
        int exp_hc, exp_bc, h_cyc, b_cyc;
        logic [31:0] exp_hrd, exp_brd, h_rd, b_rd;
        host_first = h_en && (!b_en || ref_last_baby);
        exp_hc = !h_en ? -1 : (b_en && !host_first) ? 5 : 2;
        exp_bc = !b_en ? -1 : (h_en && host_first) ? 5 : 2;
        exp_hrd = '0; exp_brd = '0;
        for (int turn = 0; turn < 2; turn++) begin
            if (h_en && (host_first == (turn == 0))) begin
                if (h_we) model_host_wr(h_adr, h_dat, h_sel);
                else exp_hrd = model_host_rd(h_adr);
            end
            if (b_en && (host_first != (turn == 0))) begin
                if (b_we) ref_mem[b_adr] = b_dat;
                else exp_brd = ref_mem[b_adr];
            end
        end
        if (b_en && !(h_en && !host_first)) ref_last_baby = 1'b1;
        else if (h_en) ref_last_baby = 1'b0;
        txn(h_en, h_we, h_adr, h_dat, h_sel, b_en, b_we, b_adr, b_dat, h_cyc, h_rd, b_cyc, b_rd);
        if (h_en) check({tag, "_hcyc"}, 32'(h_cyc), 32'(exp_hc));
        if (b_en) check({tag, "_bcyc"}, 32'(b_cyc), 32'(exp_bc));
        if (h_en && !h_we) check({tag, "_hrd"}, h_rd, exp_hrd);
        if (b_en && !b_we) check({tag, "_brd"}, b_rd, exp_brd);
    endtask

    task automatic pulse_reset();
        @(negedge wb_clk_i);
        wb_rst_i = 1'b1;
        repeat (2) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        model_reset();
    endtask

    initial begin
        int w0;
        logic [31:0] a;
        bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0; bus.wbs_we_i = 0; bus.wbs_sel_i = 0;
        bus.wbs_adr_i = 0; bus.wbs_dat_i = 0;
        bus.baby_req_i = 0; bus.baby_we_i = 0; bus.baby_addr_i = 0; bus.baby_data_i = 0;
        bus.baby_stop_i = 0;
        for (int i = 0; i < 32; i++) ref_mem[i] = '0;
        model_reset();

        repeat (2) @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        check("rst_wbs_ack", 32'(bus.wbs_ack_o), 32'd0);
        check("rst_baby_ack", 32'(bus.baby_ack_o), 32'd0);
        check("rst_wbs_dat", bus.wbs_dat_o, 32'd0);
        check("rst_baby_dat", bus.baby_data_o, 32'd0);
        check("rst_ram_addr", 32'(bus.ram_addr_o), 32'd0);
        check("rst_ram_we", 32'(bus.ram_we_o), 32'd0);
        check("rst_ram_data", bus.ram_data_o, 32'd0);
        check("rst_baby_reset", 32'(bus.baby_reset_o), 32'd1);
        wb_rst_i = 1'b0;
        ram_clear = 1'b0;

        do_op("tie_after_reset", 1, 0, 32'h80, 0, 4'hF, 1, 0, 5'd3, 0);
        do_op("tie_again", 1, 0, 32'h80, 0, 4'hF, 1, 0, 5'd3, 0);
        do_op("host_only", 1, 0, 32'h84, 0, 4'hF, 0, 0, 0, 0);
        do_op("tie_baby_wins", 1, 0, 32'h80, 0, 4'hF, 1, 0, 5'd3, 0);

        w0 = we_cnt;
        do_op("host_wr", 1, 1, 32'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, 0);
        check("host_wr_pulses", 32'(we_cnt - w0), 32'd1);
        check("host_wr_addr", 32'(we_addr), 32'd1);
        check("host_wr_data", we_data, 32'hDEADBEEF);
        do_op("host_rd", 1, 0, 32'h04, 0, 4'hF, 0, 0, 0, 0);
        w0 = we_cnt;
        do_op("host_wr_sel3", 1, 1, 32'h04, 32'h0BADF00D, 4'h3, 0, 0, 0, 0);
        check("sel3_no_pulse", 32'(we_cnt - w0), 32'd0);
        do_op("host_rd_sel3", 1, 0, 32'h04, 0, 4'hF, 0, 0, 0, 0);

        do_op("run_on", 1, 1, 32'h80, 32'h1, 4'h0, 0, 0, 0, 0);
        check("run_reset_at_ack", 32'(br_at_ack), 32'd1);
        check("run_reset_after", 32'(bus.baby_reset_o), 32'd0);
        bus.baby_stop_i = 1'b1;
        do_op("ctrl_stop", 1, 0, 32'hFFFF_FF80, 0, 4'hF, 0, 0, 0, 0);
        do_op("unmapped", 1, 0, 32'h84, 0, 4'hF, 0, 0, 0, 0);

        do_op("baby_wr31", 0, 0, 0, 0, 0, 1, 1, 5'd31, 32'h12345678);
        do_op("baby_rd31", 0, 0, 0, 0, 0, 1, 0, 5'd31, 0);
        do_op("host_rd_baby31", 1, 0, 32'h7C, 0, 4'hF, 0, 0, 0, 0);

        // Reset while a host read sits in RESP.
        @(negedge wb_clk_i);
        bus.wbs_cyc_i = 1; bus.wbs_stb_i = 1; bus.wbs_we_i = 0; bus.wbs_adr_i = 32'h04;
        repeat (2) begin @(posedge wb_clk_i); @(negedge wb_clk_i); end
        wb_rst_i = 1'b1;
        #1;
        check("midrst_no_ack", 32'(bus.wbs_ack_o), 32'd0);
        bus.wbs_cyc_i = 0; bus.wbs_stb_i = 0;
        @(posedge wb_clk_i);
        @(negedge wb_clk_i);
        check("midrst_ack_after", 32'(bus.wbs_ack_o), 32'd0);
        check("midrst_baby_reset", 32'(bus.baby_reset_o), 32'd1);
        wb_rst_i = 1'b0;
        model_reset();
        do_op("midrst_ctrl", 1, 0, 32'h80, 0, 4'hF, 0, 0, 0, 0);

        pulse_reset();
        for (int n = 0; n < 60; n++) begin
            int kind, hk;
            logic [3:0] sel;
            kind = $urandom_range(0, 2);
            hk   = $urandom_range(0, 3);
            a    = $urandom;
            case (hk)
                0, 1: a[7] = 1'b0;
                2:    a[7:2] = 6'h20;
                default: begin
                    a[7] = 1'b1;
                    if (a[6:2] == 5'd0) a[6:2] = 5'd1;
                end
            endcase
            sel = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            bus.baby_stop_i = 1'($urandom_range(0, 1));
            do_op($sformatf("rnd%0d", n), kind != 1, 1'($urandom_range(0, 1)), a, $urandom, sel,
                  kind != 0, 1'($urandom_range(0, 1)), 5'($urandom), $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
